key_event: RTL and testbench

Key gesture classifier placed directly downstream of the key debouncer. It consumes one debounced key level and emits registered single-cycle event pulses: short click, long press and, when compiled in, double click. Its outputs drive the mode/control FSMs, which therefore never see raw key levels or need their own timers.

---
 rtl/key_pkg.sv | 24 ++
 rtl/key_edge.sv | 24 ++
 rtl/key_event.sv | 160 ++++++++++++++++
 tb/tb_key_event.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared key-path types and timing defaults for the debouncer, gesture classifier and timers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package key_pkg;

    // Width of every key-path cycle counter; all time constants stay below 2^KEY_CNT_W.
    localparam int KEY_CNT_W = 20;

    // Defaults at a 100 kHz core clock.
    localparam int KEY_CLK_HZ        = 100000;
    localparam int KEY_DEBOUNCE_TIME = 2000;    // 20 ms
    localparam int KEY_LONG_TIME     = 100000;  // 1 s
    localparam int KEY_DBL_GAP       = 30000;   // 0.3 s

    // Gesture classifier states; WAIT_GAP and SECOND are only reached with double click built in.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_GAP  = 3'd3,
        SECOND    = 3'd4
    } key_state_t;

endpackage

// File: rtl/key_edge.sv
// Registers the debounced key level and flags its rising edge.
// Latency: rise is combinational on key_in against the one-cycle-old level.
// Backpressure: none; the strobe is valid for exactly the cycle it is asserted.
module key_edge (
    input  logic clk_100kHz,
    input  logic rst_,
    input  logic key_in,
    output logic rise
);

    logic key_d;

    // Previous key level; resets to "pressed" so a key held through reset is not a new press.
    always_ff @(posedge clk_100kHz or negedge rst_) begin
        if (!rst_) begin
            key_d <= 1'b1;
        end else begin
            key_d <= key_in;
        end
    end

    assign rise = key_in & ~key_d;

endmodule

// File: rtl/key_event.sv
// Classifies a debounced key into short-click, long-press and (with KEY_EVENT_DBLCLICK_EN) double-click pulses.
// Latency: pulses are registered, one cycle after the deciding edge; short click waits DBL_GAP more with double click built in.
// Backpressure: none; every pulse is a single-cycle strobe that consumers must capture.
import key_pkg::*;

module key_event #(
    parameter int LONG_TIME = KEY_LONG_TIME,
    parameter int DBL_GAP   = KEY_DBL_GAP
) (
    input  logic clk_100kHz,
    input  logic rst_,
    input  logic key_in,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic busy
);

    // Both time parameters must be at least 2 and fit the counter without wrapping.
    if (LONG_TIME < 2 || LONG_TIME >= (1 << KEY_CNT_W) ||
        DBL_GAP   < 2 || DBL_GAP   >= (1 << KEY_CNT_W)) begin : g_param_range
        $error("key_event: LONG_TIME and DBL_GAP must lie in 2..2^20-1");
    end

    localparam logic [KEY_CNT_W-1:0] LONG_LAST = KEY_CNT_W'(LONG_TIME - 1);
`ifdef KEY_EVENT_DBLCLICK_EN
    localparam logic [KEY_CNT_W-1:0] GAP_LAST  = KEY_CNT_W'(DBL_GAP - 1);
`endif

    key_state_t            state;
    key_state_t            state_nxt;
    logic [KEY_CNT_W-1:0]  cnt;
    logic [KEY_CNT_W-1:0]  cnt_nxt;
    logic                  rise;
    logic                  short_nxt;
    logic                  long_nxt;
    logic                  double_nxt;

    key_edge u_key_edge (
        .clk_100kHz (clk_100kHz),
        .rst_       (rst_),
        .key_in     (key_in),
        .rise       (rise)
    );

    // State, counter and registered pulse/busy outputs.
    always_ff @(posedge clk_100kHz or negedge rst_) begin
        if (!rst_) begin
            state       <= IDLE;
            cnt         <= '0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            short_pulse <= short_nxt;
            long_pulse  <= long_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

`ifdef KEY_EVENT_DBLCLICK_EN
    // Double-click pulse register, present only when the gap states exist.
    always_ff @(posedge clk_100kHz or negedge rst_) begin
        if (!rst_) begin
            double_pulse <= 1'b0;
        end else begin
            double_pulse <= double_nxt;
        end
    end
`else
    assign double_pulse = 1'b0;
`endif

    // Next state and counter: hold timer in PRESSED, gap timer in WAIT_GAP.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end
            end
            PRESSED: begin
                if (key_in) begin
                    if (cnt == LONG_LAST) begin
                        state_nxt = LONG_HELD;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
`ifdef KEY_EVENT_DBLCLICK_EN
                    state_nxt = WAIT_GAP;
                    cnt_nxt   = '0;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            LONG_HELD: begin
                if (!key_in) begin
                    state_nxt = IDLE;
                end
            end
`ifdef KEY_EVENT_DBLCLICK_EN
            WAIT_GAP: begin
                // A second press on the timeout cycle still counts as a double click.
                if (rise) begin
                    state_nxt = SECOND;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SECOND: begin
                if (!key_in) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pulse decode: each pulse belongs to a distinct state, so at most one fires per cycle.
    always_comb begin
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
        case (state)
            PRESSED: begin
                long_nxt = key_in && (cnt == LONG_LAST);
`ifndef KEY_EVENT_DBLCLICK_EN
                short_nxt = !key_in;
`endif
            end
`ifdef KEY_EVENT_DBLCLICK_EN
            WAIT_GAP: begin
                short_nxt = !rise && (cnt == GAP_LAST);
            end
            SECOND: begin
                double_nxt = !key_in;
            end
`endif
            default: begin
                short_nxt  = 1'b0;
                long_nxt   = 1'b0;
                double_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_event.sv
module tb_key_event;

    localparam int LT = 20;
    localparam int DG = 10;

    localparam int K_SHORT  = 0;
    localparam int K_LONG   = 1;
    localparam int K_DOUBLE = 2;

    logic clk_100kHz = 1'b0;
    logic rst_       = 1'b0;
    logic key_in     = 1'b0;
    logic short_pulse;
    logic long_pulse;
    logic double_pulse;
    logic busy;

    key_event #(
        .LONG_TIME (LT),
        .DBL_GAP   (DG)
    ) dut (
        .clk_100kHz   (clk_100kHz),
        .rst_         (rst_),
        .key_in       (key_in),
        .short_pulse  (short_pulse),
        .long_pulse   (long_pulse),
        .double_pulse (double_pulse),
        .busy         (busy)
    );

    always #5 clk_100kHz = ~clk_100kHz;

    // Edge counter: after posedge N settles, cyc == N.
    int cyc = 0;
    always @(posedge clk_100kHz) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int edge_n;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t cyc=%0d)", nm, act, req, $time, cyc);
        end
    endtask

    task automatic expect_pulse(input int kind, input int edge_n);
        exp_t e;
        e.kind   = kind;
        e.edge_n = edge_n;
        q.push_back(e);
    endtask

    // Drive a level sampled at the next n edges; call and return #1 after a posedge.
    task automatic hold(input logic lvl, input int n);
        key_in = lvl;
        repeat (n) @(posedge clk_100kHz);
        #1;
    endtask

    // Monitor: every pulse seen must match the head of the expectation queue.
    always @(negedge clk_100kHz) begin : monitor
        int n;
        int k;
        exp_t e;
        if (rst_) begin
            n = int'(short_pulse) + int'(long_pulse) + int'(double_pulse);
            if (n > 1) chk("pulses_one_hot", n, 1);
            if (n != 0) begin
                k = long_pulse ? K_LONG : (short_pulse ? K_SHORT : K_DOUBLE);
                if (q.size() == 0) begin
                    chk("unexpected_pulse_kind", k, -1);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", k, e.kind);
                    chk("pulse_cycle", cyc, e.edge_n);
                end
            end
        end
    end

    initial begin
        // Reset state.
        rst_   = 1'b0;
        key_in = 1'b0;
        repeat (3) @(posedge clk_100kHz);
        #1;
        chk("rst_short", short_pulse, 0);
        chk("rst_long", long_pulse, 0);
        chk("rst_double", double_pulse, 0);
        chk("rst_busy", busy, 0);
        rst_ = 1'b1;
        hold(1'b0, 3);

        // Short click: 5-cycle hold.
        hold(1'b1, 1);
        chk("short_busy_after_rise", busy, 1);
        hold(1'b1, 4);
`ifdef KEY_EVENT_DBLCLICK_EN
        expect_pulse(K_SHORT, cyc + 1 + DG);
        hold(1'b0, 1);
        chk("short_busy_in_gap", busy, 1);
`else
        expect_pulse(K_SHORT, cyc + 1);
        hold(1'b0, 1);
        chk("short_busy_after_release", busy, 0);
`endif
        hold(1'b0, DG + 5);
        chk("short_busy_idle", busy, 0);

        // Long press: 30-cycle hold, pulse after E0+LT, nothing on release.
        hold(1'b1, 1);
        expect_pulse(K_LONG, cyc + LT);
        hold(1'b1, 29);
        chk("long_busy_held", busy, 1);
        hold(1'b0, 1);
        chk("long_busy_after_release", busy, 0);
        hold(1'b0, DG + 5);

        // Two quick presses with a 4-cycle gap.
        hold(1'b1, 3);
`ifndef KEY_EVENT_DBLCLICK_EN
        expect_pulse(K_SHORT, cyc + 1);
`endif
        hold(1'b0, 4);
        hold(1'b1, 3);
`ifdef KEY_EVENT_DBLCLICK_EN
        expect_pulse(K_DOUBLE, cyc + 1);
`else
        expect_pulse(K_SHORT, cyc + 1);
`endif
        hold(1'b0, 1);
        chk("dbl_busy_after_release", busy, 0);
        hold(1'b0, DG + 5);

        // Second rise exactly on the gap timeout edge (cnt == DG-1).
        hold(1'b1, 3);
`ifndef KEY_EVENT_DBLCLICK_EN
        expect_pulse(K_SHORT, cyc + 1);
`endif
        hold(1'b0, DG);
        hold(1'b1, 2);
`ifdef KEY_EVENT_DBLCLICK_EN
        expect_pulse(K_DOUBLE, cyc + 1);
`else
        expect_pulse(K_SHORT, cyc + 1);
`endif
        hold(1'b0, DG + 5);

        // A following press is a fresh gesture.
        hold(1'b1, 2);
`ifdef KEY_EVENT_DBLCLICK_EN
        expect_pulse(K_SHORT, cyc + 1 + DG);
`else
        expect_pulse(K_SHORT, cyc + 1);
`endif
        hold(1'b0, DG + 5);

        // Key held through reset release: no gesture.
        key_in = 1'b1;
        rst_   = 1'b0;
        hold(1'b1, 2);
        rst_ = 1'b1;
        hold(1'b1, LT + 5);
        chk("held_reset_busy", busy, 0);
        hold(1'b0, DG + 5);
        chk("held_reset_busy_after_release", busy, 0);

        // Reset mid-hold aborts immediately, no long pulse later.
        hold(1'b1, 10);
        chk("abort_busy_before", busy, 1);
        rst_ = 1'b0;
        #1;
        chk("abort_short", short_pulse, 0);
        chk("abort_long", long_pulse, 0);
        chk("abort_double", double_pulse, 0);
        chk("abort_busy", busy, 0);
        hold(1'b1, 3);
        rst_ = 1'b1;
        hold(1'b1, LT + 10);
        chk("abort_busy_after", busy, 0);
        hold(1'b0, DG + 5);

        chk("expected_pulses_left", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
